// File: rtl/cnn_pkg.sv
// cnn_pkg: shared datapath width, pixel type and pooling-scheduler state encoding
package cnn_pkg;
    localparam int DATA_W    = 16;
    localparam int WIN_BEATS = 4;
    typedef logic signed [DATA_W-1:0] pix_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} pool_state_e;
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: 2x2 window walker producing input-buffer read addresses
// ports: clk, reset; clear_i restarts at window (0,0); adv_i steps one beat;
//        rd_addr_o current read address; slot_o high on read beats (low on the bubble);
//        last_beat_o high on the 4th read beat of the final window
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int FM_W   = 28,
    parameter int FM_H   = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              slot_o,
    output logic              last_beat_o
);
    localparam logic [2:0]        BUB      = 3'(WIN_BEATS);
    localparam logic [ADDR_W-1:0] FW       = ADDR_W'(FM_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * FM_W);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(FM_W / 2 - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(FM_H / 2 - 1);

    logic [2:0]        beat_q;
    logic [ADDR_W-1:0] col_q, row_q, rb_q;
    logic              bubble, end_col;

    assign bubble      = beat_q == BUB;
    assign end_col     = col_q == COL_LAST;
    assign slot_o      = !bubble;
    assign last_beat_o = beat_q == 3'(WIN_BEATS - 1) && end_col && row_q == ROW_LAST;
    // beat[0] selects the right column, beat[1] the lower row of the window
    assign rd_addr_o   = rb_q + (col_q << 1) + (beat_q[1] ? FW : '0) + ADDR_W'(beat_q[0]);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            beat_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            rb_q   <= '0;
        end else if (adv_i) begin
            beat_q <= bubble ? '0 : beat_q + 3'd1;
            if (bubble) begin
                col_q <= end_col ? '0 : col_q + 1'b1;
                row_q <= end_col ? row_q + 1'b1 : row_q;
                rb_q  <= end_col ? rb_q + ROW_STEP : rb_q;
            end
        end
    end
endmodule

// File: rtl/pool_window_sched.sv
// pool_window_sched: sequencer feeding a 2x2 max-pool PE and writing pooled results
// ports: start/hold control, busy/done status; rd_* input-buffer read port;
//        pe_* drive and capture of the PE; wr_* output-buffer write port;
//        win_count (only with POOL_SCHED_STATS_EN) counts writes of the current/last pass
module pool_window_sched
    import cnn_pkg::*;
#(
    parameter int FM_W   = 28,
    parameter int FM_H   = 28,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     pe_start,
    output logic                     pe_enable,
    output logic signed [DATA_W-1:0] pe_data,
    input  logic signed [DATA_W-1:0] pe_result,
    input  logic                     pe_flag,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data
`ifdef POOL_SCHED_STATS_EN
    ,
    output logic [15:0]              win_count
`endif
);
    if (FM_W * FM_H > (1 << ADDR_W)) begin : g_bad_size
        $error("pool_window_sched: FM_W*FM_H exceeds the ADDR_W address space");
    end

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic              pe_en_q, accept, adv, slot, last_beat;

    assign accept    = state_q == S_IDLE && start;
    assign adv       = state_q == S_RUN && !hold;
    assign rd_en     = adv && slot;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign pe_start  = state_q == S_RUN || state_q == S_DRAIN;
    assign pe_enable = pe_en_q;
    // zero outside enabled beats so the PE reloads its max with 0 on the flag cycle
    assign pe_data   = pe_en_q ? rd_data : '0;
    assign wr_en     = pe_flag && pe_start;
    assign wr_data   = wr_en ? pe_result : '0;
    assign wr_addr   = oidx_q;

    always_comb begin
        state_d = accept ? S_RUN
                : (rd_en && last_beat) ? S_DRAIN
                : (state_q == S_DRAIN && pe_flag) ? S_DONE
                : done ? S_IDLE : state_q;
        oidx_d  = done ? '0 : wr_en ? oidx_q + 1'b1 : oidx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            oidx_q  <= '0;
            pe_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            oidx_q  <= oidx_d;
            pe_en_q <= rd_en;
        end
    end

    pool_addr_gen #(.FM_W(FM_W), .FM_H(FM_H), .ADDR_W(ADDR_W)) u_addr (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (rd_en && last_beat),
        .adv_i       (adv),
        .rd_addr_o   (rd_addr),
        .slot_o      (slot),
        .last_beat_o (last_beat)
    );

`ifdef POOL_SCHED_STATS_EN
    logic [15:0] win_q, win_d;
    assign win_d     = accept ? '0 : (wr_en && win_q != 16'hFFFF) ? win_q + 16'd1 : win_q;
    assign win_count = win_q;
    always_ff @(posedge clk) win_q <= reset ? '0 : win_d;
`endif
endmodule

// File: tb/tb_pool_window_sched.sv
// tb_pool_window_sched: directed checks of the pooling sequencer against buffer and PE models
module tb_pool_window_sched;
    typedef struct { int c; int a; int d; } ev_t;

    logic clk = 1'b0, reset = 1'b1, hold = 1'b0;
    logic [1:0] start = '0, inj = '0;
    int cyc = 0, pass_cnt = 0, total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = 4 + g;
        logic busy, done, rd_en, pe_start, pe_enable, pe_flag, wr_en;
        logic [9:0] rd_addr, wr_addr;
        logic signed [15:0] pe_data, pe_result, wr_data;
        logic signed [15:0] rd_data = '0, pmax = '0;
        logic [2:0] pcnt = '0;
        logic signed [15:0] mem [32];
`ifdef POOL_SCHED_STATS_EN
        logic [15:0] win_count;
`endif
        ev_t wlog[$], rlog[$];
        int dcyc = -1;

        pool_window_sched #(.FM_W(W), .FM_H(W), .ADDR_W(10)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .hold(hold),
            .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
            .pe_start(pe_start), .pe_enable(pe_enable), .pe_data(pe_data),
            .pe_result(pe_result), .pe_flag(pe_flag),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef POOL_SCHED_STATS_EN
            , .win_count(win_count)
`endif
        );

        assign pe_flag   = pcnt == 3'd4 || inj[g];
        assign pe_result = pmax;

        always @(posedge clk) begin
            if (rd_en) rd_data <= mem[rd_addr[4:0]];
            if (!pe_start) begin
                pcnt <= '0;
                pmax <= '0;
            end else if (pcnt == 3'd4) begin
                pcnt <= '0;
                pmax <= pe_data;
            end else if (pe_enable) begin
                pcnt <= pcnt + 3'd1;
                pmax <= (pe_data > pmax) ? pe_data : pmax;
            end
        end

        always @(negedge clk) begin
            if (wr_en) wlog.push_back('{cyc, int'(wr_addr), int'(wr_data)});
            if (rd_en) rlog.push_back('{cyc, int'(rd_addr), 0});
            if (done) dcyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill4();
        for (int i = 0; i < 16; i++) u[0].mem[i] = 16'(i);
    endtask

    task automatic go0(output int t0);
        u[0].wlog.delete();
        u[0].rlog.delete();
        u[0].dcyc = -1;
        start[0] = 1'b1;
        t0 = cyc;
        step();
        start[0] = 1'b0;
    endtask

    task automatic wait_done0(input int t0, input int lim);
        for (int n = 0; n < lim && u[0].dcyc < t0; n++) step();
        total++;
        if (u[0].dcyc < t0) $display("FAIL done_timeout: no done within %0d cycles", lim);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if ({u[0].busy, u[0].done, u[0].rd_en, u[0].pe_start, u[0].pe_enable, u[0].wr_en} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {u[0].busy, u[0].done, u[0].rd_en, u[0].pe_start, u[0].pe_enable, u[0].wr_en});
        else pass_cnt++;
        total++;
        if ({u[0].rd_addr, u[0].wr_addr} !== 20'd0)
            $display("FAIL reset_addr: rd %0d wr %0d want 0 0", u[0].rd_addr, u[0].wr_addr);
        else pass_cnt++;
        total++;
        if ({u[0].pe_data, u[0].wr_data, u[1].busy} !== 33'd0)
            $display("FAIL reset_data: pe_data %0d wr_data %0d busy1 %b want 0 0 0",
                     u[0].pe_data, u[0].wr_data, u[1].busy);
        else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int t0;
        int e[4] = '{5, 7, 13, 15};
        int ra[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int bad;
        fill4();
        go0(t0);
        wait_done0(t0, 60);
        total++;
        if (u[0].wlog.size() != 4) $display("FAIL basic_count: got %0d writes want 4", u[0].wlog.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < u[0].wlog.size(); i++) begin
            total++;
            if (u[0].wlog[i].c - t0 !== 6 + 5 * i || u[0].wlog[i].a !== i || u[0].wlog[i].d !== e[i])
                $display("FAIL basic_wr%0d: cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                         i, u[0].wlog[i].c - t0, u[0].wlog[i].a, u[0].wlog[i].d, 6 + 5 * i, i, e[i]);
            else pass_cnt++;
        end
        bad = (u[0].rlog.size() != 16) ? 1 : 0;
        for (int i = 0; i < 16 && i < u[0].rlog.size(); i++)
            if (u[0].rlog[i].c - t0 != 5 * (i / 4) + 1 + i % 4 || u[0].rlog[i].a != ra[i]) bad++;
        total++;
        if (bad != 0) $display("FAIL basic_reads: %0d bad of %0d reads, want 0 bad of 16", bad, u[0].rlog.size());
        else pass_cnt++;
        total++;
        if (u[0].dcyc - t0 !== 22) $display("FAIL basic_done: done at %0d want 22", u[0].dcyc - t0);
        else pass_cnt++;
        total++;
        if (u[0].busy !== 1'b0) $display("FAIL basic_busy: busy %b at cycle 23 want 0", u[0].busy);
        else pass_cnt++;
    endtask

    task automatic test_zero_reload();
        int t0;
        int e[4] = '{0, 9, 4, 1};
        for (int i = 0; i < 16; i++) u[0].mem[i] = 16'sd0;
        u[0].mem[2] = 16'sd3; u[0].mem[3] = 16'sd9; u[0].mem[6] = 16'sd1; u[0].mem[7] = 16'sd2;
        u[0].mem[8] = 16'sd4;
        u[0].mem[10] = 16'sd1; u[0].mem[11] = 16'sd1; u[0].mem[14] = 16'sd1; u[0].mem[15] = 16'sd1;
        go0(t0);
        wait_done0(t0, 60);
        total++;
        if (u[0].wlog.size() != 4) $display("FAIL reload_count: got %0d writes want 4", u[0].wlog.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < u[0].wlog.size(); i++) begin
            total++;
            if (u[0].wlog[i].d !== e[i] || u[0].wlog[i].a !== i)
                $display("FAIL reload_wr%0d: addr %0d data %0d want addr %0d data %0d",
                         i, u[0].wlog[i].a, u[0].wlog[i].d, i, e[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int t0;
        int e[4] = '{5, 7, 13, 15};
        fill4();
        go0(t0);
        for (int n = 0; n < 60 && u[0].dcyc < t0; n++) begin
            hold = (cyc - t0 >= 3 && cyc - t0 <= 5);
            step();
        end
        hold = 1'b0;
        total++;
        if (u[0].dcyc - t0 !== 25) $display("FAIL hold_done: done at %0d want 25", u[0].dcyc - t0);
        else pass_cnt++;
        total++;
        if (u[0].wlog.size() != 4) $display("FAIL hold_count: got %0d writes want 4", u[0].wlog.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < u[0].wlog.size(); i++) begin
            total++;
            if (u[0].wlog[i].c - t0 !== 9 + 5 * i || u[0].wlog[i].d !== e[i])
                $display("FAIL hold_wr%0d: cyc %0d data %0d want cyc %0d data %0d",
                         i, u[0].wlog[i].c - t0, u[0].wlog[i].d, 9 + 5 * i, e[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        fill4();
        go0(t0);
        while (cyc - t0 < 8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({u[0].busy, u[0].done, u[0].rd_en, u[0].pe_start, u[0].pe_enable, u[0].wr_en,
             u[0].rd_addr, u[0].wr_addr, u[0].pe_data, u[0].wr_data} !== 58'd0)
            $display("FAIL midreset_outs: busy %b rd_en %b pe_start %b pe_en %b rd_addr %0d wr_addr %0d want all 0",
                     u[0].busy, u[0].rd_en, u[0].pe_start, u[0].pe_enable, u[0].rd_addr, u[0].wr_addr);
        else pass_cnt++;
        for (int n = 0; n < 20; n++) step();
        total++;
        if (u[0].wlog.size() != 1 || u[0].busy !== 1'b0)
            $display("FAIL midreset_quiet: %0d writes busy %b want 1 write busy 0", u[0].wlog.size(), u[0].busy);
        else pass_cnt++;
        test_basic();
    endtask

    task automatic test_start_ignored();
        int t0, b23;
        int e[4] = '{6, 8, 16, 18};
        int ra[16] = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
        int bad;
        for (int i = 0; i < 25; i++) u[1].mem[i] = 16'(i);
        u[1].wlog.delete();
        u[1].rlog.delete();
        u[1].dcyc = -1;
        b23 = -1;
        start[1] = 1'b1;
        t0 = cyc;
        step();
        while (cyc - t0 < 32) begin
            start[1] = (cyc - t0 == 4 || cyc - t0 == 22);
            if (cyc - t0 == 23) b23 = int'(u[1].busy);
            step();
        end
        start[1] = 1'b0;
        total++;
        if (u[1].wlog.size() != 4) $display("FAIL ign_count: got %0d writes want 4", u[1].wlog.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < u[1].wlog.size(); i++) begin
            total++;
            if (u[1].wlog[i].c - t0 !== 6 + 5 * i || u[1].wlog[i].a !== i || u[1].wlog[i].d !== e[i])
                $display("FAIL ign_wr%0d: cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                         i, u[1].wlog[i].c - t0, u[1].wlog[i].a, u[1].wlog[i].d, 6 + 5 * i, i, e[i]);
            else pass_cnt++;
        end
        bad = (u[1].rlog.size() != 16) ? 1 : 0;
        for (int i = 0; i < 16 && i < u[1].rlog.size(); i++)
            if (u[1].rlog[i].a != ra[i]) bad++;
        total++;
        if (bad != 0) $display("FAIL ign_reads: %0d bad of %0d reads, want 0 bad of 16", bad, u[1].rlog.size());
        else pass_cnt++;
        total++;
        if (u[1].dcyc - t0 !== 22 || b23 !== 0)
            $display("FAIL ign_done: done at %0d busy@23 %0d want 22 and 0", u[1].dcyc - t0, b23);
        else pass_cnt++;
    endtask

    task automatic test_flag_idle();
        inj[0] = 1'b1;
        @(negedge clk);
        total++;
        if (u[0].wr_en !== 1'b0 || u[0].wr_data !== 16'sd0)
            $display("FAIL idle_flag: wr_en %b wr_data %0d want 0 0", u[0].wr_en, u[0].wr_data);
        else pass_cnt++;
        step();
        inj[0] = 1'b0;
        step();
        total++;
        if (u[0].wr_addr !== 10'd0) $display("FAIL idle_flag_addr: wr_addr %0d want 0", u[0].wr_addr);
        else pass_cnt++;
    endtask

`ifdef POOL_SCHED_STATS_EN
    task automatic test_stats();
        int t0;
        fill4();
        go0(t0);
        wait_done0(t0, 60);
        total++;
        if (u[0].win_count !== 16'd4) $display("FAIL stats_count: win_count %0d want 4", u[0].win_count);
        else pass_cnt++;
        go0(t0);
        total++;
        if (u[0].win_count !== 16'd0) $display("FAIL stats_clear: win_count %0d want 0", u[0].win_count);
        else pass_cnt++;
        wait_done0(t0, 60);
    endtask
`endif

    initial begin
        step();
        test_reset();
        test_basic();
        test_zero_reload();
        test_hold();
        test_reset_mid();
        test_start_ignored();
        test_flag_idle();
`ifdef POOL_SCHED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
